// File: rtl/i2c_slave_regs.sv
// I2C slave with eight 8-bit registers: [dev addr + R/W][register index] then data bytes.
// Optional: define I2C_SLAVE_AUTOINC_EN to advance the register pointer after every data byte.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_valid,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, MEM_ADDR, MEM_ADDR_ACK,
    WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] regs [8];
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [3:0] bit_cnt;
  logic [2:0] ptr;
  logic [2:0] ptr_inc;
  logic       rw;
  logic       sda_oe;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // START/STOP need scl high in both the current and previous sample so an
  // scl edge coinciding with an sda change is never mistaken for either.
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_inc = ptr + 3'd1;
`else
  assign ptr_inc = ptr;
`endif

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      // NOTE: the register file is small and must read back 00 after reset, so
      // it is cleared here rather than left to power-up contents.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every branch below sees the
      // values from the start of this clock, regardless of statement order.
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      wr_valid <= 1'b0;

      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        busy    <= 1'b1;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        if (scl_rise && (state == ADDR || state == MEM_ADDR || state == WRITE)
            && bit_cnt < 4'd8) begin
          rx_shift <= {rx_shift[6:0], sda_s2};
          bit_cnt  <= bit_cnt + 4'd1;
        end

        case (state)
          ADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              if (rx_shift[7:1] == SLAVE_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                rw     <= rx_shift[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              state   <= MEM_ADDR;
              bit_cnt <= '0;
            end
          end
          MEM_ADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              if (rx_shift[7:3] == 5'b00000) begin
                ptr    <= rx_shift[2:0];
                sda_oe <= 1'b1;
                state  <= MEM_ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          MEM_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                state    <= READ;
                sda_oe   <= ~regs[ptr][7];
                tx_shift <= {regs[ptr][6:0], 1'b0};
              end else begin
                state  <= WRITE;
                sda_oe <= 1'b0;
              end
            end
          end
          WRITE: begin
            // Commit one clk after the 8th rise; ACK starts at the following scl fall.
            if (bit_cnt == 4'd8) begin
              regs[ptr] <= rx_shift;
              wr_valid  <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_shift;
              ptr       <= ptr_inc;
              state     <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                state   <= WRITE;
                bit_cnt <= '0;
              end
            end
          end
          READ: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= READ_ACK;
                ptr    <= ptr_inc;
              end else begin
                sda_oe   <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            // bit_cnt = 9 marks "master ACKed, reload at the next fall".
            if (scl_rise) begin
              if (sda_s2) state <= IGNORE;
              else        bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              state    <= READ;
              bit_cnt  <= '0;
              sda_oe   <= ~regs[ptr][7];
              tx_shift <= {regs[ptr][6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1111111: 7-bit address this device answers to.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port scl  input  1  I2C clock from the bus master, oversampled by clk.
REQ-005 SHALL have port sda  inout  1  I2C data; the block drives only 0 or Z (open-drain).
REQ-006 SHALL have port busy  output  1  high from detected START to detected STOP.
REQ-007 SHALL have port wr_valid  output  1  one-clk pulse per committed register write.
REQ-008 SHALL have port wr_addr  output  3  register index of the last committed write.
REQ-009 SHALL have port wr_data  output  8  byte of the last committed write.
REQ-010 SHALL have port dbg_sel  input  3  register index for the debug read port.
REQ-011 SHALL have port dbg_data  output  8  combinational contents of register dbg_sel.

Function
REQ-012 SHALL pass scl and sda through 2-flop synchronizers and detect edges on the synchronized values only.
REQ-013 SHALL hold 8 registers of 8 bits, indexed by a 3-bit pointer.
REQ-014 SHALL detect START as sda falling while scl high, from any state: go to ADDR, bit counter 0, busy=1.
REQ-015 SHALL detect STOP as sda rising while scl high, from any state: go to IDLE, release sda, busy=0.
REQ-016 SHALL use states IDLE, ADDR, ADDR_ACK, MEM_ADDR, MEM_ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-017 SHALL sample sda on each synchronized scl rising edge and shift bytes in MSB first.
REQ-018 ADDR SHALL capture 7 address bits plus R/W bit; on match, drive ACK (0); on mismatch, go to IGNORE with sda released until STOP.
REQ-019 SHALL drive every ACK from the scl falling edge after bit 8 until the scl falling edge after bit 9.
REQ-020 MEM_ADDR SHALL ACK only when bits [7:3] are 00000, load the pointer from [2:0] and go to MEM_ADDR_ACK; otherwise it SHALL NACK and go to IGNORE.
REQ-021 After MEM_ADDR_ACK, the captured R/W bit SHALL select the next state: R/W=0 selects WRITE, R/W=1 selects READ; there is no repeated START.
REQ-022 WRITE SHALL, one clk after the 8th data-bit scl rise, write the byte to the register at the pointer, pulse wr_valid, update wr_addr/wr_data, and ACK.
REQ-023 READ SHALL drive register[pointer] MSB first; each bit changes on the scl falling edge, the first bit on the falling edge that ends MEM_ADDR_ACK; a 1 bit is driven as Z.
REQ-024 READ_ACK SHALL release sda and sample the master bit on the 9th scl rise: ACK (0) continues with the next byte in READ; NACK (1) goes to IGNORE.
REQ-025 A simultaneous START or STOP and scl edge SHALL give START/STOP priority.
REQ-026 wr_valid SHALL never be high in two consecutive clks.
REQ-027 An aborted byte (START/STOP before bit 8) SHALL leave registers unchanged and produce no wr_valid.

Reset
REQ-028 rst SHALL set: state IDLE, sda released, busy=0, wr_valid=0, wr_addr=0, wr_data=0, pointer 0, all registers 8'h00, synchronizers 1.
REQ-029 rst asserted mid-transfer SHALL release sda on the next clk edge; after release the block ignores the bus until the next START.

Configuration
REQ-030 Macro I2C_SLAVE_AUTOINC_EN defined: the pointer SHALL increment after each written or read byte, wrapping 7 to 0.
REQ-031 Macro I2C_SLAVE_AUTOINC_EN undefined: the pointer SHALL stay fixed for the whole transfer; repeated bytes rewrite or reread the same register.

Verification
REQ-032 Write addr 7'h7F/W, mem 8'h05, data 8'hA5, STOP -> three ACKs, one wr_valid with wr_addr=5 and wr_data=A5, dbg_sel=5 gives A5.
REQ-033 Preload reg3=8'h3C; send 7'h7F/R, mem 8'h03, read 1 byte, master ACK, STOP -> master receives 8'h3C; sda released after STOP.
REQ-034 Address 7'h12/W -> no ACK (sda Z at bit 9), IGNORE until STOP, no wr_valid, registers unchanged.
REQ-035 Mem byte 8'h09 -> NACK at bit 9, no register change.
REQ-036 With AUTOINC_EN: write mem 7, data 11, 22 -> reg7=11, reg0=22 (wrap). Without AUTOINC_EN: reg7=22, reg0 unchanged.
REQ-037 Assert rst after bit 4 of a write byte -> sda Z next clk, registers 00, no wr_valid; a following full write succeeds.
